// File: rtl/kan_layer_sequencer.sv
// ============================================================================
// Module   : kan_layer_sequencer
// Purpose  : Walks one KAN layer pass (tile x feature x grid point) and
//            emits lockstep grid-index / weight-address AXI-Stream beats,
//            counts datapath result beats and reports done / error.
// Options  : KAN_SEQ_PERF_CNT_EN adds stall / run-cycle performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kan_layer_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int GIDX_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [CNT_WIDTH-1:0]  cfg_in_count,
    input  logic [GIDX_WIDTH-1:0] cfg_grid_count,
    input  logic [CNT_WIDTH-1:0]  cfg_tile_count,
    output logic [GIDX_WIDTH-1:0] m_axis_gidx_tdata,
    output logic                  m_axis_gidx_tvalid,
    input  logic                  m_axis_gidx_tready,
    output logic                  m_axis_gidx_tlast,
    output logic [ADDR_WIDTH-1:0] m_axis_waddr_tdata,
    output logic                  m_axis_waddr_tvalid,
    input  logic                  m_axis_waddr_tready,
    output logic                  m_axis_waddr_tlast,
    input  logic                  s_rslt_tvalid,
    input  logic                  s_rslt_tready,
    input  logic                  s_rslt_tlast,
    input  logic                  err_unalligned_data,
    input  logic                  err_user_flag,
    output logic                  busy,
    output logic                  done,
    output logic                  error
`ifdef KAN_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_run_cycles
`endif
);

    localparam int TOT_W  = 2 * CNT_WIDTH + GIDX_WIDTH;
    localparam int TOT_W1 = TOT_W + 1;
    localparam logic [TOT_W:0] c_addr_span = TOT_W1'(1) << ADDR_WIDTH;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_error = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [CNT_WIDTH-1:0]  r_n_cnt;
    logic [GIDX_WIDTH-1:0] r_g_cnt;
    logic [CNT_WIDTH-1:0]  r_t_cnt;

    logic [GIDX_WIDTH-1:0] r_g;
    logic [CNT_WIDTH-1:0]  r_i;
    logic [CNT_WIDTH-1:0]  r_t;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_gidx_acc;
    logic                  r_waddr_acc;
    logic [CNT_WIDTH-1:0]  r_rcnt;
    logic                  r_error;

    logic [TOT_W-1:0]      w_total;
    logic                  w_cfg_bad;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_gidx_fire;
    logic                  w_waddr_fire;
    logic                  w_step;
    logic                  w_last_g;
    logic                  w_last_i;
    logic                  w_last_t;
    logic                  w_last_step;
    logic                  w_active;
    logic                  w_rslt_fire;
    logic                  w_rslt_ovf;
    logic                  w_fault;
    logic                  w_rslt_all_in;

    // A pass longer than the weight address space cannot be addressed.
    assign w_total = TOT_W'(cfg_tile_count) * TOT_W'(cfg_in_count) * TOT_W'(cfg_grid_count);
    assign w_cfg_bad = (cfg_in_count == '0) || (cfg_grid_count == '0) || (cfg_tile_count == '0)
                     || ({1'b0, w_total} > c_addr_span);

    assign w_start_ok  = (r_state == c_st_idle) && cfg_start && !w_cfg_bad;
    assign w_start_bad = (r_state == c_st_idle) && cfg_start && w_cfg_bad;

    assign w_gidx_fire  = m_axis_gidx_tvalid && m_axis_gidx_tready;
    assign w_waddr_fire = m_axis_waddr_tvalid && m_axis_waddr_tready;
    assign w_step       = (r_state == c_st_run) && (r_gidx_acc || w_gidx_fire)
                        && (r_waddr_acc || w_waddr_fire);

    assign w_last_g    = (r_g == r_g_cnt - GIDX_WIDTH'(1));
    assign w_last_i    = (r_i == r_n_cnt - CNT_WIDTH'(1));
    assign w_last_t    = (r_t == r_t_cnt - CNT_WIDTH'(1));
    assign w_last_step = w_step && w_last_g && w_last_i && w_last_t;

    assign w_active      = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_rslt_fire   = s_rslt_tvalid && s_rslt_tready && s_rslt_tlast && (r_state != c_st_idle);
    assign w_rslt_all_in = (r_rcnt == r_t_cnt);
    assign w_rslt_ovf    = w_rslt_fire && w_rslt_all_in;
    assign w_fault       = w_active && (err_unalligned_data || err_user_flag || w_rslt_ovf);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start_ok) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_run: begin
                if (w_fault) begin
                    w_next_state = c_st_error;
                end else if (w_last_step) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_fault) begin
                    w_next_state = c_st_error;
                end else if (w_rslt_all_in) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Outputs: a beat stays valid until its own handshake, then waits for its partner.
    always_comb begin
        busy                = w_active;
        done                = (r_state == c_st_drain) && w_rslt_all_in && !w_fault;
        m_axis_gidx_tvalid  = (r_state == c_st_run) && !r_gidx_acc;
        m_axis_waddr_tvalid = (r_state == c_st_run) && !r_waddr_acc;
        m_axis_gidx_tlast   = m_axis_gidx_tvalid && w_last_g;
        m_axis_waddr_tlast  = m_axis_waddr_tvalid && w_last_g && w_last_i;
    end

    assign m_axis_gidx_tdata  = r_g;
    assign m_axis_waddr_tdata = r_waddr;
    assign error              = r_error;

    // Loop counters, handshake flags, result counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n_cnt     <= '0;
            r_g_cnt     <= '0;
            r_t_cnt     <= '0;
            r_g         <= '0;
            r_i         <= '0;
            r_t         <= '0;
            r_waddr     <= '0;
            r_gidx_acc  <= 1'b0;
            r_waddr_acc <= 1'b0;
            r_rcnt      <= '0;
            r_error     <= 1'b0;
        end else if (w_start_ok) begin
            r_n_cnt     <= cfg_in_count;
            r_g_cnt     <= cfg_grid_count;
            r_t_cnt     <= cfg_tile_count;
            r_g         <= '0;
            r_i         <= '0;
            r_t         <= '0;
            r_waddr     <= '0;
            r_gidx_acc  <= 1'b0;
            r_waddr_acc <= 1'b0;
            r_rcnt      <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_start_bad || w_fault) begin
                r_error <= 1'b1;
            end
            if (w_step) begin
                r_gidx_acc  <= 1'b0;
                r_waddr_acc <= 1'b0;
                if (!w_last_step) begin
                    r_waddr <= r_waddr + ADDR_WIDTH'(1);
                    if (w_last_g) begin
                        r_g <= '0;
                        if (w_last_i) begin
                            r_i <= '0;
                            r_t <= r_t + CNT_WIDTH'(1);
                        end else begin
                            r_i <= r_i + CNT_WIDTH'(1);
                        end
                    end else begin
                        r_g <= r_g + GIDX_WIDTH'(1);
                    end
                end
            end else begin
                r_gidx_acc  <= r_gidx_acc || w_gidx_fire;
                r_waddr_acc <= r_waddr_acc || w_waddr_fire;
            end
            if (w_rslt_fire && !w_rslt_ovf) begin
                r_rcnt <= r_rcnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef KAN_SEQ_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_run   <= '0;
        end else if (w_start_ok) begin
            r_perf_stall <= '0;
            r_perf_run   <= '0;
        end else begin
            if ((r_state == c_st_run)
                && ((m_axis_gidx_tvalid && !m_axis_gidx_tready)
                    || (m_axis_waddr_tvalid && !m_axis_waddr_tready))) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_active) begin
                r_perf_run <= r_perf_run + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_run_cycles   = r_perf_run;
`endif

endmodule

`default_nettype wire

// File: tb/tb_kan_layer_sequencer.sv
// ============================================================================
// Module   : tb_kan_layer_sequencer
// Purpose  : Randomized self-checking bench for kan_layer_sequencer against a
//            loop-nest reference model of the expected beat streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kan_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [11:0] cfg_in_count = '0;
    logic [7:0]  cfg_grid_count = '0;
    logic [11:0] cfg_tile_count = '0;
    logic [7:0]  gidx_tdata;
    logic        gidx_tvalid, gidx_tlast;
    logic        gidx_tready = 1'b0;
    logic [15:0] waddr_tdata;
    logic        waddr_tvalid, waddr_tlast;
    logic        waddr_tready = 1'b0;
    logic        rslt_tvalid = 1'b0, rslt_tready = 1'b0, rslt_tlast = 1'b0;
    logic        err_unal = 1'b0, err_user = 1'b0;
    logic        busy, done, error;
`ifdef KAN_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_run_cycles;
`endif

    kan_layer_sequencer #(.ADDR_WIDTH(16), .GIDX_WIDTH(8), .CNT_WIDTH(12)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_start           (cfg_start),
        .cfg_in_count        (cfg_in_count),
        .cfg_grid_count      (cfg_grid_count),
        .cfg_tile_count      (cfg_tile_count),
        .m_axis_gidx_tdata   (gidx_tdata),
        .m_axis_gidx_tvalid  (gidx_tvalid),
        .m_axis_gidx_tready  (gidx_tready),
        .m_axis_gidx_tlast   (gidx_tlast),
        .m_axis_waddr_tdata  (waddr_tdata),
        .m_axis_waddr_tvalid (waddr_tvalid),
        .m_axis_waddr_tready (waddr_tready),
        .m_axis_waddr_tlast  (waddr_tlast),
        .s_rslt_tvalid       (rslt_tvalid),
        .s_rslt_tready       (rslt_tready),
        .s_rslt_tlast        (rslt_tlast),
        .err_unalligned_data (err_unal),
        .err_user_flag       (err_user),
        .busy                (busy),
        .done                (done),
        .error               (error)
`ifdef KAN_SEQ_PERF_CNT_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_run_cycles     (perf_run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed handshakes, sampled at the falling edge ahead of the capturing edge.
    logic [8:0]  obs_g[$];
    logic [16:0] obs_w[$];
    logic [8:0]  exp_g[$];
    logic [16:0] exp_w[$];
    int          done_cnt = 0;
    int          tiles_obs = 0;
    logic        pg_pend = 1'b0, pw_pend = 1'b0;
    logic [8:0]  pg_data;
    logic [16:0] pw_data;

    always @(negedge clk) begin
        if (!rst) begin
            pg_pend = 1'b0;
            pw_pend = 1'b0;
        end else begin
            if (pg_pend && busy) check("gidx_hold", {gidx_tvalid, gidx_tlast, gidx_tdata}, {1'b1, pg_data});
            if (pw_pend && busy) check("waddr_hold", {waddr_tvalid, waddr_tlast, waddr_tdata}, {1'b1, pw_data});
            if (gidx_tvalid && gidx_tready) obs_g.push_back({gidx_tlast, gidx_tdata});
            if (waddr_tvalid && waddr_tready) begin
                obs_w.push_back({waddr_tlast, waddr_tdata});
                if (waddr_tlast) tiles_obs++;
            end
            if (done) done_cnt++;
            pg_pend = gidx_tvalid && !gidx_tready;
            pg_data = {gidx_tlast, gidx_tdata};
            pw_pend = waddr_tvalid && !waddr_tready;
            pw_data = {waddr_tlast, waddr_tdata};
        end
    end

    // Reference: the expected streams are just the loop nest t / i / g in order.
    task automatic build_model(input int n, input int g, input int t);
        int addr = 0;
        exp_g.delete();
        exp_w.delete();
        for (int tt = 0; tt < t; tt++)
            for (int ii = 0; ii < n; ii++)
                for (int gg = 0; gg < g; gg++) begin
                    exp_g.push_back({1'(gg == g - 1), 8'(gg)});
                    exp_w.push_back({1'((ii == n - 1) && (gg == g - 1)), 16'(addr)});
                    addr++;
                end
    endtask

    task automatic clear_obs();
        obs_g.delete();
        obs_w.delete();
        done_cnt  = 0;
        tiles_obs = 0;
    endtask

    task automatic do_start(input int n, input int g, input int t);
        @(posedge clk); #1;
        cfg_in_count   = 12'(n);
        cfg_grid_count = 8'(g);
        cfg_tile_count = 12'(t);
        cfg_start      = 1'b1;
        @(posedge clk); #1;
        cfg_start      = 1'b0;
    endtask

    // mode 0: readies high, 1: gidx ready toggles, 2: random readies and result strobes
    task automatic run_case(input int n, input int g, input int t, input int mode);
        int sent = 0;
        int cyc  = 0;
        build_model(n, g, t);
        clear_obs();
        gidx_tready  = (mode == 1) ? 1'b0 : 1'b1;
        waddr_tready = 1'b1;
        do_start(n, g, t);
        check("first_valid", {gidx_tvalid, waddr_tvalid, busy, error}, 4'b1110);
        while (done_cnt == 0 && cyc < 3000) begin
            if (mode == 1) gidx_tready = ~gidx_tready;
            if (mode == 2) begin
                gidx_tready  = 1'($urandom_range(0, 1));
                waddr_tready = 1'($urandom_range(0, 1));
            end
            rslt_tvalid = 1'b0; rslt_tready = 1'b0; rslt_tlast = 1'b0;
            if (sent < tiles_obs) begin
                if (mode == 2) begin
                    rslt_tvalid = 1'($urandom_range(0, 1));
                    rslt_tready = 1'($urandom_range(0, 1));
                    rslt_tlast  = 1'($urandom_range(0, 1));
                end else begin
                    rslt_tvalid = 1'b1; rslt_tready = 1'b1; rslt_tlast = 1'b1;
                end
                if (rslt_tvalid && rslt_tready && rslt_tlast) sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        rslt_tvalid = 1'b0; rslt_tready = 1'b0; rslt_tlast = 1'b0;
        check($sformatf("done_seen n%0d g%0d t%0d", n, g, t), 1'(done_cnt > 0), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("end_idle", {busy, error, gidx_tvalid, waddr_tvalid}, 4'b0000);
        check("n_gidx", obs_g.size(), exp_g.size());
        check("n_waddr", obs_w.size(), exp_w.size());
        for (int k = 0; k < exp_g.size(); k++) begin
            if (k < obs_g.size()) check($sformatf("gidx[%0d]", k), obs_g[k], exp_g[k]);
            if (k < obs_w.size()) check($sformatf("waddr[%0d]", k), obs_w[k], exp_w[k]);
        end
    endtask

    task automatic cfg_err(input int n, input int g, input int t);
        clear_obs();
        do_start(n, g, t);
        for (int k = 0; k < 3; k++) begin
            check("cfgerr_quiet", {busy, gidx_tvalid, waddr_tvalid}, 3'b000);
            @(posedge clk); #1;
        end
        check("cfgerr_flag", error, 1'b1);
    endtask

    initial begin
        #2;
        check("rst_ctrl", {busy, done, error}, 3'b000);
        check("rst_valid", {gidx_tvalid, gidx_tlast, waddr_tvalid, waddr_tlast}, 4'b0000);
        check("rst_data", {gidx_tdata, waddr_tdata}, 24'h0);
        #10 rst = 1'b1;

        run_case(2, 3, 1, 0);
        run_case(1, 4, 2, 1);
        cfg_err(2, 0, 1);
        cfg_err(16, 17, 256);

        // Datapath error after the third beat.
        clear_obs();
        gidx_tready = 1'b1; waddr_tready = 1'b1;
        do_start(2, 3, 1);
        for (int k = 0; k < 20 && obs_g.size() < 3; k++) begin
            @(posedge clk); #1;
        end
        err_user = 1'b1;
        @(posedge clk); #1;
        err_user = 1'b0;
        check("errflag_stop", {gidx_tvalid, waddr_tvalid, busy, error}, 4'b0001);
        @(posedge clk); #1;
        check("errflag_idle", {gidx_tvalid, busy, error}, 3'b001);
        repeat (3) @(posedge clk);
        #1;
        check("errflag_nodone", done_cnt, 0);

        // Extra result when all T results are already in.
        clear_obs();
        gidx_tready = 1'b0; waddr_tready = 1'b0;
        do_start(1, 2, 1);
        check("ovf_clear", error, 1'b0);
        rslt_tvalid = 1'b1; rslt_tready = 1'b1; rslt_tlast = 1'b1;
        @(posedge clk); #1;
        check("ovf_first_ok", {busy, error}, 2'b10);
        @(posedge clk); #1;
        rslt_tvalid = 1'b0; rslt_tready = 1'b0; rslt_tlast = 1'b0;
        check("ovf_error", {busy, error, gidx_tvalid}, 3'b010);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_nodone", done_cnt, 0);

        // Exactly 2^16 beats is legal; abort it with an asynchronous reset.
        gidx_tready = 1'b1; waddr_tready = 1'b1;
        do_start(256, 1, 256);
        check("span_accept", {busy, error}, 2'b10);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_out", {busy, done, error, gidx_tvalid, waddr_tvalid}, 5'b00000);
        check("arst_data", {gidx_tdata, waddr_tdata}, 24'h0);
        #7 rst = 1'b1;
        run_case(1, 1, 1, 0);

        for (int r = 0; r < 6; r++)
            run_case($urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(0, 2));

`ifdef KAN_SEQ_PERF_CNT_EN
        clear_obs();
        gidx_tready = 1'b0; waddr_tready = 1'b0;
        do_start(1, 2, 1);
        repeat (5) @(posedge clk);
        #1;
        gidx_tready = 1'b1; waddr_tready = 1'b1;
        for (int k = 0; k < 20 && tiles_obs == 0; k++) begin
            @(posedge clk); #1;
        end
        rslt_tvalid = 1'b1; rslt_tready = 1'b1; rslt_tlast = 1'b1;
        @(posedge clk); #1;
        rslt_tvalid = 1'b0; rslt_tready = 1'b0; rslt_tlast = 1'b0;
        for (int k = 0; k < 20 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
        end
        check("perf_done", done_cnt, 1);
        check("perf_stall", perf_stall_cycles, 32'd5);
        check("perf_run_gt", 1'(perf_run_cycles > 32'd7), 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
